// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Brief    : Memory-mapped interrupt controller: rising-edge latch, per-line
//            mask, fixed priority (line 0 highest) and an ACK-by-ID handshake.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             rw,
    input  logic [3:0]       reg_sel,
    input  logic [31:0]      data_in,
    output logic [31:0]      data_out,
    input  logic [N_IRQ-1:0] irq,
    output logic             intr
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    localparam logic [3:0] c_sel_id      = 4'h0;
    localparam logic [3:0] c_sel_ack     = 4'h1;
    localparam logic [3:0] c_sel_mask    = 4'h2;
    localparam logic [3:0] c_sel_pending = 4'h3;

    logic [N_IRQ-1:0] r_irq_prev;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [ID_W-1:0]  r_irq_id;
    logic [0:0]       r_state;

    logic             w_wr;
    logic             w_ack_wr;
    logic             w_mask_wr;
    logic [ID_W-1:0]  w_ack_id;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_cur;
    logic [N_IRQ-1:0] w_pending_nxt;
    logic [N_IRQ-1:0] w_mask_nxt;
    logic [N_IRQ-1:0] w_req;
    logic             w_active;
    logic [ID_W-1:0]  w_sel;
    logic             w_ack_hit;
    logic             w_cur_live;
    logic [31:0]      w_rd_data;
    logic             w_unused_data;

    assign w_wr      = ce && !rw;
    assign w_ack_wr  = w_wr && (reg_sel == c_sel_ack);
    assign w_mask_wr = w_wr && (reg_sel == c_sel_mask);
    assign w_ack_id  = data_in[ID_W-1:0];
    assign w_rise    = irq & ~r_irq_prev;

    // Per-line decode: ACK IDs at or above N_IRQ match no line and are dropped.
    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
            assign w_clr[gi] = w_ack_wr && (w_ack_id == ID_W'(gi));
            assign w_cur[gi] = (r_irq_id == ID_W'(gi));
        end
    endgenerate

    // A new edge wins over a same-cycle ACK so no interrupt is ever lost.
    assign w_pending_nxt = (r_pending & ~w_clr) | w_rise;
    assign w_mask_nxt    = w_mask_wr ? data_in[N_IRQ-1:0] : r_mask;
    assign w_req         = r_pending & r_mask;
    assign w_active      = |w_req;
    assign w_ack_hit     = w_ack_wr && (w_ack_id == r_irq_id);
    assign w_cur_live    = |(w_pending_nxt & w_mask_nxt & w_cur);

    always_comb begin
        w_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_sel = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_prev <= '0;
            r_pending  <= '0;
            r_mask     <= '0;
            r_irq_id   <= '0;
            r_state    <= S_IDLE;
        end else begin
            r_irq_prev <= irq;
            r_pending  <= w_pending_nxt;
            r_mask     <= w_mask_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_active) begin
                        r_irq_id <= w_sel;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    // Leave on a matching ACK, or when the serviced line is masked off.
                    if (w_ack_hit || !w_cur_live) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign intr = (r_state == S_REQ);

    always_comb begin
        w_rd_data = '0;
        if (ce && rw) begin
            case (reg_sel)
                c_sel_id:      w_rd_data[ID_W-1:0]  = r_irq_id;
                c_sel_mask:    w_rd_data[N_IRQ-1:0] = r_mask;
                c_sel_pending: w_rd_data[N_IRQ-1:0] = r_pending;
                default:       w_rd_data = '0;
            endcase
        end
    end

    assign data_out      = w_rd_data;
    assign w_unused_data = ^data_in;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Brief    : Directed bench for irq_controller; reads queue their expected
//            data_out/intr, an independent monitor pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        rw;
    logic [3:0]  reg_sel;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [7:0]  irq;
    logic        intr;
    logic        chk;

    typedef struct {
        string       name;
        logic [31:0] data;
        logic        intr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    irq_controller #(.N_IRQ(8), .ID_W(5)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ce       (ce),
        .rw       (rw),
        .reg_sel  (reg_sel),
        .data_in  (data_in),
        .data_out (data_out),
        .irq      (irq),
        .intr     (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] sel, input logic [31:0] d, input logic en = 1'b1);
        ce      = en;
        rw      = 1'b0;
        reg_sel = sel;
        data_in = d;
        tick();
        ce      = 1'b0;
        rw      = 1'b1;
        data_in = '0;
    endtask

    task automatic do_read(input logic [3:0] sel, input logic [31:0] d, input logic i,
                           input string nm, input logic en = 1'b1);
        ce      = en;
        rw      = 1'b1;
        reg_sel = sel;
        chk     = 1'b1;
        exp_q.push_back('{nm, d, i});
        tick();
        ce      = 1'b0;
        chk     = 1'b0;
    endtask

    // Monitor: every strobed read cycle consumes one queued expectation.
    always @(negedge clk) begin
        if (chk) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_read actual=%h required=<queued entry>", data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data_out !== e.data) begin
                    n_errors++;
                    $display("FAIL %s data_out actual=%h required=%h", e.name, data_out, e.data);
                end
                n_checks++;
                if (intr !== e.intr) begin
                    n_errors++;
                    $display("FAIL %s intr actual=%b required=%b", e.name, intr, e.intr);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; ce = 1'b0; rw = 1'b1; reg_sel = '0; data_in = '0; irq = '0; chk = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;

        do_read(4'h0, 32'h0, 1'b0, "reset_id");
        do_read(4'h2, 32'h0, 1'b0, "reset_mask");
        do_read(4'h3, 32'h0, 1'b0, "reset_pending");

        // Basic service of line 0
        do_write(4'h2, 32'h01);
        irq = 8'h01;
        tick();
        do_read(4'h3, 32'h01, 1'b0, "basic_pending");
        do_read(4'h0, 32'h00, 1'b1, "basic_req");
        irq = 8'h00;
        do_write(4'h1, 32'd0);
        do_read(4'h3, 32'h00, 1'b0, "basic_acked");
        do_read(4'h0, 32'h00, 1'b0, "basic_idle");

        // Priority between simultaneous lines 5 and 2
        do_write(4'h2, 32'hFF);
        irq = 8'h24;
        tick();
        tick();
        do_read(4'h0, 32'd2, 1'b1, "prio_first");
        do_write(4'h1, 32'd2);
        do_read(4'h3, 32'h20, 1'b0, "prio_gap");
        do_read(4'h0, 32'd5, 1'b1, "prio_second");
        do_write(4'h1, 32'd5);
        do_read(4'h3, 32'h00, 1'b0, "prio_done");
        do_read(4'h0, 32'd5, 1'b0, "prio_idle");
        irq = 8'h00;
        tick();

        // No preemption of line 4 by line 1
        irq = 8'h10;
        tick();
        tick();
        irq = 8'h12;
        tick();
        do_read(4'h0, 32'd4, 1'b1, "nopre_id");
        do_read(4'h3, 32'h12, 1'b1, "nopre_pending");
        do_write(4'h1, 32'd4);
        do_read(4'h3, 32'h02, 1'b0, "nopre_gap");
        do_read(4'h0, 32'd1, 1'b1, "nopre_next");
        do_write(4'h1, 32'd1);
        irq = 8'h00;
        tick();

        // Mask gating on line 3
        do_write(4'h2, 32'h00);
        irq = 8'h08;
        tick();
        tick();
        do_read(4'h3, 32'h08, 1'b0, "mask_latched");
        do_write(4'h2, 32'h08);
        tick();
        do_read(4'h0, 32'd3, 1'b1, "mask_enabled");
        do_write(4'h2, 32'h00);
        do_read(4'h3, 32'h08, 1'b0, "mask_dropped");
        do_read(4'h0, 32'd3, 1'b0, "mask_held_id");
        do_write(4'h1, 32'd3);
        irq = 8'h00;
        do_read(4'h3, 32'h00, 1'b0, "mask_cleanup");

        // Set-vs-clear collision on line 6
        do_write(4'h2, 32'h40);
        irq = 8'h40;
        tick();
        tick();
        do_read(4'h0, 32'd6, 1'b1, "coll_req");
        irq = 8'h00;
        tick();
        irq = 8'h40;
        do_write(4'h1, 32'd6);
        do_read(4'h3, 32'h40, 1'b0, "coll_kept");
        do_read(4'h0, 32'd6, 1'b1, "coll_rereq");
        do_write(4'h1, 32'd6);
        do_read(4'h3, 32'h00, 1'b0, "coll_acked");
        tick();
        tick();
        do_read(4'h3, 32'h00, 1'b0, "coll_no_retrigger");

        // Reset while in REQ
        irq = 8'h00;
        tick();
        do_write(4'h2, 32'h81);
        irq = 8'h81;
        tick();
        tick();
        do_read(4'h3, 32'h81, 1'b1, "rst_pre");
        rst_n = 1'b0;
        irq   = 8'h00;
        tick();
        rst_n = 1'b1;
        do_read(4'h3, 32'h00, 1'b0, "rst_pending");
        do_read(4'h2, 32'h00, 1'b0, "rst_mask");

        // Bus hygiene
        do_write(4'h2, 32'h5A);
        irq = 8'h80;
        tick();
        do_read(4'h7, 32'h00, 1'b0, "undef_sel");
        do_read(4'h1, 32'h00, 1'b0, "ack_not_readable");
        do_write(4'h1, 32'd31);
        do_read(4'h3, 32'h80, 1'b0, "ack_out_of_range");
        do_write(4'h3, 32'h00);
        do_read(4'h3, 32'h80, 1'b0, "ro_write_ignored");
        do_write(4'h2, 32'hFF, 1'b0);
        do_read(4'h2, 32'h5A, 1'b0, "ce0_write_ignored");
        do_read(4'h2, 32'h00, 1'b0, "ce0_read_zero", 1'b0);
        do_write(4'h2, 32'hFFFF_FF00);
        do_read(4'h2, 32'h00, 1'b0, "mask_upper_ignored");

        tick();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_queue actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Programmable interrupt controller (PIC) on the memory-mapped peripheral bus. It sits behind the peripheral address decoder, which supplies its chip-enable, rw and 4-bit register select. It latches rising edges on N_IRQ interrupt lines and masks them. It arbitrates by fixed priority and drives a single interrupt request to the MIPS core, holding it until software acknowledges by writing the serviced ID.

Parameters:
N_IRQ, 8, number of interrupt input lines (1..32); line 0 has the highest priority.
ID_W, 5, width of the interrupt ID field (must satisfy 2^ID_W >= N_IRQ).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  synchronous active-low reset.
ce  input  1  chip-enable from the peripheral decoder.
rw  input  1  1 = read, 0 = write; qualified by ce.
reg_sel  input  4  register select, i.e. address[11:8] from the decoder.
data_in  input  32  write data.
data_out  output  32  read data.
irq  input  N_IRQ  interrupt request lines, level-stable and synchronous to clk.
intr  output  1  interrupt request to the CPU.

Behaviour:
- Reset (rst_n=0 sampled at an edge):
  - irq_prev, pending, mask and irq_id are cleared to 0.
  - FSM goes to IDLE; intr=0.
  - Reset overrides any concurrent write or edge.
- Edge detect:
  - rise[i] = irq[i] & ~irq_prev[i].
  - irq_prev <= irq every cycle.
  - pending[i] <= 1 on the cycle after rise[i]; masked lines still latch.
- Register map:
  - 0x0 IRQ_ID, RO: {zero, irq_id}.
  - 0x1 ACK, WO: data_in[ID_W-1:0] = acknowledged ID.
  - 0x2 MASK, RW: bit i = 1 enables line i. Bits >= N_IRQ are read as 0 and writes to them are ignored.
  - 0x3 PENDING, RO.
  - Writes to RO registers and to undefined selects are ignored; reads of undefined selects return 0.
- Register access:
  - Reads are combinational: data_out is valid in the same cycle that ce=1 and rw=1, so a monocycle load completes in one cycle.
  - data_out = 0 when ce=0 or rw=0.
  - Writes take effect at the clock edge.
- ACK write: clears pending[data_in[ID_W-1:0]] if that ID < N_IRQ. IDs >= N_IRQ are ignored.
- Same-cycle set and clear on one bit: set wins, so a new edge is never lost.
- Priority: sel = lowest index i with pending[i] & mask[i]; active = |(pending & mask).
- FSM:
  - IDLE: intr=0. If active, then irq_id <= sel and go to REQ.
  - REQ: intr=1 and irq_id is held stable (higher-priority arrivals do not preempt). Exit to IDLE when either:
    - an ACK write has ID == irq_id, or
    - pending[irq_id] & mask[irq_id] becomes 0 (line masked by a MASK write).
  - The transition out of REQ takes one edge. IDLE then needs one more cycle before a new REQ, so intr is low for at least 1 cycle between two services.
- An ACK with ID != irq_id in REQ clears that other pending bit only; the FSM stays in REQ.
- Latency: irq rising at edge t gives pending at t+1, intr=1 at t+2 (IDLE, line unmasked). ACK write at edge a gives intr=0 after a.
- A line that is still high does not retrigger; only a new 0->1 transition sets pending.
- Reset in REQ: intr drops and all pending bits are lost.

Test Plan:
- Basic service: MASK=0x01; pulse irq[0] high at cycle 10 -> PENDING=0x01 after 11, intr=1 from 12, IRQ_ID=0. Write ACK=0 -> intr=0 next cycle, PENDING=0.
- Priority: MASK=0xFF; raise irq[5] and irq[2] in the same cycle -> IRQ_ID=2. ACK 2 -> intr low 1 cycle, then intr=1 with IRQ_ID=5. ACK 5 -> PENDING=0, intr stays 0.
- No preemption: in REQ with IRQ_ID=4, raise irq[1] -> IRQ_ID stays 4, PENDING=0x12. ACK 4 -> next service has IRQ_ID=1.
- Mask gating: MASK=0x00; edge on irq[3] -> PENDING=0x08, intr stays 0. Write MASK=0x08 -> intr=1 two cycles later with IRQ_ID=3. Write MASK=0 while in REQ -> intr=0 next cycle, PENDING still 0x08.
- Set-vs-clear collision: in REQ for line 6, drop irq[6] and re-raise it so the edge lands in the same cycle as the ACK 6 write -> PENDING bit 6 remains 1, and intr re-asserts after 1 low cycle. Also hold irq[6] high with no new edge -> no retrigger.
- Reset and bus hygiene:
  - rst_n=0 while in REQ with PENDING=0x81 -> intr=0, PENDING=0, MASK=0 next cycle.
  - Reading reg_sel=0x7 -> data_out=0.
  - Writing ACK=31 with N_IRQ=8 -> no state change.
  - With ce=0, data_out=0 and writes have no effect.
